// File: rtl/reg_bank8_32_if.sv
// ---------------------------------------------------------------------------
// reg_bank8_32_if
// Bus bundle for the reg_bank8_32 register bank.
//   clr                      synchronous clear request
//   wa_en/wa_addr/wa_be/wa_data   write port A (wins byte collisions)
//   wb_en/wb_addr/wb_be/wb_data   write port B
//   rd_addr / rd_data        registered readback with write bypass
//   q0..q7                   register contents feeding the 8:1 select mux
//   valid                    per-register "written since reset/clear" mask
// Modports: master drives requests, slave is the register bank.
// ---------------------------------------------------------------------------
interface reg_bank8_32_if #(
    parameter int WIDTH = 32
);
    localparam int NBYTE = WIDTH / 8;

    logic             clr;
    logic             wa_en;
    logic [2:0]       wa_addr;
    logic [NBYTE-1:0] wa_be;
    logic [WIDTH-1:0] wa_data;
    logic             wb_en;
    logic [2:0]       wb_addr;
    logic [NBYTE-1:0] wb_be;
    logic [WIDTH-1:0] wb_data;
    logic [2:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0]       valid;

    modport master (
        output clr,
        output wa_en, wa_addr, wa_be, wa_data,
        output wb_en, wb_addr, wb_be, wb_data,
        output rd_addr,
        input  rd_data,
        input  q0, q1, q2, q3, q4, q5, q6, q7,
        input  valid
    );

    modport slave (
        input  clr,
        input  wa_en, wa_addr, wa_be, wa_data,
        input  wb_en, wb_addr, wb_be, wb_data,
        input  rd_addr,
        output rd_data,
        output q0, q1, q2, q3, q4, q5, q6, q7,
        output valid
    );
endinterface

// File: rtl/reg_bank8_32.sv
// ---------------------------------------------------------------------------
// reg_bank8_32
// Eight WIDTH-bit registers with two byte-enabled write ports, synchronous
// clear, a sticky valid mask and a registered readback port.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears registers, valid, rd_data)
//   bus    reg_bank8_32_if.slave (write ports, readback, q0..q7, valid)
// ---------------------------------------------------------------------------
module reg_bank8_32 #(
    parameter int WIDTH = 32,
    parameter int NREG  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_bank8_32_if.slave bus
);
    localparam int NBYTE = WIDTH / 8;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [7:0]       valid_q, valid_d;
    logic [WIDTH-1:0] rd_q, rd_d;

    // Byte merge: port A has priority per byte, then port B, else hold.
    always_comb begin
        valid_d = valid_q;
        for (int n = 0; n < NREG; n++) begin
            regs_d[n] = regs_q[n];
            for (int k = 0; k < NBYTE; k++) begin
                if (bus.wa_en && (bus.wa_addr == 3'(n)) && bus.wa_be[k]) begin
                    regs_d[n][8*k +: 8] = bus.wa_data[8*k +: 8];
                    valid_d[n]          = 1'b1;
                end else if (bus.wb_en && (bus.wb_addr == 3'(n)) && bus.wb_be[k]) begin
                    regs_d[n][8*k +: 8] = bus.wb_data[8*k +: 8];
                    valid_d[n]          = 1'b1;
                end
            end
        end
        if (bus.clr) begin
            for (int n = 0; n < NREG; n++) begin
                regs_d[n] = '0;
            end
            valid_d = '0;
        end
        // Readback samples the post-edge value, so same-edge writes bypass.
        rd_d = regs_d[bus.rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= '0;
            end
            valid_q <= '0;
            rd_q    <= '0;
        end else begin
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= regs_d[n];
            end
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.q0      = regs_q[0];
    assign bus.q1      = regs_q[1];
    assign bus.q2      = regs_q[2];
    assign bus.q3      = regs_q[3];
    assign bus.q4      = regs_q[4];
    assign bus.q5      = regs_q[5];
    assign bus.q6      = regs_q[6];
    assign bus.q7      = regs_q[7];
    assign bus.valid   = valid_q;
    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_reg_bank8_32.sv
// ---------------------------------------------------------------------------
// tb_reg_bank8_32
// Directed bench for reg_bank8_32 with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_reg_bank8_32;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    reg_bank8_32_if #(.WIDTH(32)) bus ();

    reg_bank8_32 #(.WIDTH(32), .NREG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_q(input int idx);
        case (idx)
            0: get_q = bus.q0;
            1: get_q = bus.q1;
            2: get_q = bus.q2;
            3: get_q = bus.q3;
            4: get_q = bus.q4;
            5: get_q = bus.q5;
            6: get_q = bus.q6;
            default: get_q = bus.q7;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clr = 1'b0;
        bus.wa_en = 1'b0; bus.wa_addr = 3'd0; bus.wa_be = 4'h0; bus.wa_data = '0;
        bus.wb_en = 1'b0; bus.wb_addr = 3'd0; bus.wb_be = 4'h0; bus.wb_data = '0;
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.wa_en = 1'b1; bus.wa_addr = a; bus.wa_be = be; bus.wa_data = d;
    endtask

    task automatic wr_b(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_be = be; bus.wb_data = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        bus.rd_addr = 3'd0;
        #12;
        for (int i = 0; i < 8; i++) chk($sformatf("por_q%0d", i), get_q(i), 32'h0);
        chk("por_valid", 32'(bus.valid), 32'h0);
        chk("por_rd", bus.rd_data, 32'h0);
        rst_n = 1'b1;
        step();

        // 1. Asynchronous reset mid-cycle
        wr_a(3'd1, 4'hF, 32'h5555_AAAA);
        bus.rd_addr = 3'd1;
        step();
        chk("pre_rst_q1", bus.q1, 32'h5555_AAAA);
        chk("pre_rst_rd", bus.rd_data, 32'h5555_AAAA);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q1", bus.q1, 32'h0);
        chk("async_rst_valid", 32'(bus.valid), 32'h0);
        chk("async_rst_rd", bus.rd_data, 32'h0);
        idle();
        wr_a(3'd3, 4'hF, 32'hDEAD_BEEF);
        bus.clr = 1'b0;
        step();
        chk("rst_hold_q3", bus.q3, 32'h0);
        chk("rst_hold_valid", 32'(bus.valid), 32'h0);
        #2 rst_n = 1'b1;
        step();
        chk("first_edge_q3", bus.q3, 32'hDEAD_BEEF);
        chk("first_edge_valid", 32'(bus.valid), 32'h08);
        idle();

        // 2. Byte enables
        wr_a(3'd5, 4'hF, 32'h1122_3344);
        step();
        idle();
        wr_b(3'd5, 4'b0101, 32'hAABB_CCDD);
        step();
        chk("be_q5", bus.q5, 32'h11BB_33DD);
        chk("be_valid", 32'(bus.valid), 32'h28);
        idle();
        wr_a(3'd6, 4'h0, 32'hFFFF_FFFF);
        step();
        chk("be0_q6", bus.q6, 32'h0);
        chk("be0_valid", 32'(bus.valid), 32'h28);
        idle();

        // 3. Collision merge on reg 2
        wr_a(3'd2, 4'b0011, 32'hFFFF_FFFF);
        wr_b(3'd2, 4'b1110, 32'h1234_5678);
        step();
        chk("coll_q2", bus.q2, 32'h1234_FFFF);
        chk("coll_valid", 32'(bus.valid), 32'h2C);
        idle();

        // Clear alone, then 4. dual write to different addresses
        bus.clr = 1'b1;
        step();
        chk("clr_valid", 32'(bus.valid), 32'h0);
        chk("clr_q5", bus.q5, 32'h0);
        idle();
        wr_a(3'd0, 4'hF, 32'hCAFE_BABE);
        wr_b(3'd7, 4'hF, 32'h0000_0001);
        step();
        chk("dual_q0", bus.q0, 32'hCAFE_BABE);
        chk("dual_q7", bus.q7, 32'h0000_0001);
        chk("dual_valid", 32'(bus.valid), 32'h81);
        idle();

        // 5. Readback with bypass
        bus.rd_addr = 3'd4;
        wr_a(3'd4, 4'hF, 32'h0BAD_F00D);
        step();
        chk("byp_rd", bus.rd_data, 32'h0BAD_F00D);
        chk("byp_q4", bus.q4, 32'h0BAD_F00D);
        idle();
        bus.rd_addr = 3'd1;
        step();
        chk("rd_q1", bus.rd_data, 32'h0);
        bus.rd_addr = 3'd7;
        step();
        chk("rd_q7", bus.rd_data, 32'h0000_0001);
        bus.rd_addr = 3'd0;
        wr_b(3'd0, 4'b1000, 32'h11FF_FFFF);
        step();
        chk("byp_merge_rd", bus.rd_data, 32'h11FE_BABE);
        idle();

        // 6. Clear beats same-cycle writes
        bus.rd_addr = 3'd4;
        bus.clr = 1'b1;
        wr_a(3'd1, 4'hF, 32'h1111_1111);
        wr_b(3'd2, 4'hF, 32'h2222_2222);
        step();
        for (int i = 0; i < 8; i++) chk($sformatf("clrw_q%0d", i), get_q(i), 32'h0);
        chk("clrw_valid", 32'(bus.valid), 32'h0);
        chk("clrw_rd", bus.rd_data, 32'h0);
        idle();
        bus.rd_addr = 3'd2;
        wr_a(3'd1, 4'hF, 32'h0101_0101);
        wr_b(3'd2, 4'b0011, 32'h0202_0202);
        step();
        chk("post_clr_q1", bus.q1, 32'h0101_0101);
        chk("post_clr_q2", bus.q2, 32'h0000_0202);
        chk("post_clr_rd", bus.rd_data, 32'h0000_0202);
        chk("post_clr_valid", 32'(bus.valid), 32'h06);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_bank8_32.md
Name: reg_bank8_32

Overview:
- Bank of eight 32-bit registers that drives the eight data inputs of the downstream 8:1 32-bit select mux.
- Two independent byte-enabled write ports with defined collision merging.
- Synchronous clear.
- Per-register valid mask and one registered readback port with write bypass, used by control and test logic.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- NREG, 8, register count; fixed at 8, address is 3 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all registers and the valid mask.
- wa_en  input  1  port A write enable.
- wa_addr  input  3  port A register index.
- wa_be  input  4  port A byte enables; bit k covers data[8k+7:8k].
- wa_data  input  32  port A write data.
- wb_en  input  1  port B write enable.
- wb_addr  input  3  port B register index.
- wb_be  input  4  port B byte enables.
- wb_data  input  32  port B write data.
- rd_addr  input  3  readback index.
- rd_data  output  32  registered readback data.
- q0..q7  output  32 each  current register contents; connect to mux i0..i7.
- valid  output  8  bit n set means register n has been written since the last reset or clear.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all registers, rd_data and valid go to 0 immediately, with no clock needed.
  - Writes and clr are ignored while rst_n is low.
  - Reset deasserting mid-write: no partial update; the first edge with rst_n high is the first that acts.
- q0..q7 are direct register outputs with no combinational path from inputs. A write at edge t is visible on qn after edge t.
- Port write: on each edge where en=1, bytes of register [addr] with be[k]=1 take data byte k. Bytes with be[k]=0 keep their value.
- en=1 with be=0000 writes nothing and does not set valid.
- Collision (wa_en & wb_en & wa_addr==wb_addr): per byte, port A wins where wa_be[k]=1. Otherwise port B applies where wb_be[k]=1. Otherwise the byte holds.
- Different addresses: both writes occur in the same cycle.
- valid[n] is set on an edge when any byte of register n is written by either port. It is never cleared except by clr or reset.
- clr=1 at an edge:
  - all registers and valid become 0 and rd_data becomes 0;
  - clr overrides any same-cycle write on either port.
- Readback:
  - rd_data is registered with 1-cycle latency. At edge t it loads the post-edge value of register [rd_addr], i.e. including any write landing at edge t (write bypass through the merge logic).
  - Net effect: rd_data after edge t equals q[rd_addr] after edge t.
  - rd_data updates every edge; there is no read enable.
- All index arithmetic is modulo 8, with no out-of-range case. Data is unsigned and not extended.
- No X propagation: unwritten registers read 0.

Test Plan:
1. Reset: drive writes, then pulse rst_n low asynchronously mid-cycle -> q0..q7=0, valid=00, rd_data=0 without an edge. First edge after release with wa_en=1, addr=3, data=DEADBEEF, be=F -> q3=DEADBEEF, valid=08.
2. Byte enables: q5=11223344, then port B writes AABBCCDD with be=0101 -> q5=11BB33DD, valid bit5=1. be=0000 write to reg 6 -> q6 unchanged, valid bit6 stays 0.
3. Collision: both ports target reg 2 (initial 0). A: data=FFFFFFFF, be=0011. B: data=12345678, be=1110 -> q2=1234FFFF.
4. Dual write to different addresses: A writes reg0=CAFEBABE and B writes reg7=0000_0001 in the same edge -> both land, valid=81.
5. Readback bypass: rd_addr=4 with a same-edge A write of 0BADF00D (be=F) to reg 4 -> rd_data=0BADF00D after that edge. Next cycle rd_addr=1 -> rd_data=q1.
6. Clear priority: clr=1 with simultaneous A and B writes -> all q=0, valid=00, rd_data=0. Next edge writes apply normally.
